pipe_decode_unit: RTL



---
 rtl/pipe_decode_unit.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_decode_unit.sv
// Single-issue decode stage: turns a fetched instruction word into a registered control bundle.
// Handles execute back-pressure, load-use stalls, branch flushes, halt and illegal opcodes.
module pipe_decode_unit #(
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               ctl_valid,
  output logic [REG_W-1:0]   rd0,
  output logic [REG_W-1:0]   rd1,
  output logic [REG_W-1:0]   wr,
  output logic               write,
  output logic               move,
  output logic               mem_to_reg,
  output logic               mem_write,
  output logic               branch,
  output logic               imm,
  output logic               set_quarter,
  output logic               jump_sign,
  output logic [ALUOP_W-1:0] aluop,
  output logic               halted,
  output logic               illegal
);

  localparam logic [REG_W-1:0] RegAdr  = REG_W'(4);
  localparam logic [REG_W-1:0] RegMath = REG_W'(5);
  localparam logic [REG_W-1:0] RegCnt  = REG_W'(7);

  typedef enum logic [1:0] {StRun, StStall, StHalted} state_e;

  typedef struct packed {
    logic [REG_W-1:0]   rd0;
    logic [REG_W-1:0]   rd1;
    logic [REG_W-1:0]   wr;
    logic               write;
    logic               move;
    logic               mem_to_reg;
    logic               mem_write;
    logic               branch;
    logic               imm;
    logic               set_quarter;
    logic               jump_sign;
    logic [ALUOP_W-1:0] aluop;
  } ctl_t;

  // use_rd* mark real register reads; index 0 is a valid read target
  typedef struct packed {
    ctl_t ctl;
    logic use_rd0;
    logic use_rd1;
    logic is_halt;
    logic is_illegal;
  } dec_t;

  state_e           r_state, w_state_nxt;
  ctl_t             r_ctl, w_ctl_nxt;
  ctl_t             r_skid, w_skid_nxt;
  logic             r_ctl_valid, w_valid_nxt;
  logic             r_illegal, w_illegal_nxt;
  dec_t             w_dec;
  logic [4:0]       w_op;
  logic [REG_W-1:0] w_a;
  logic [REG_W-1:0] w_b;
  logic             w_can_load;
  logic             w_hazard;

  assign w_op = instr[INSTR_W-1 -: 5];
  assign w_a  = REG_W'(instr[3:2]);
  assign w_b  = REG_W'(instr[1:0]);

  always_comb begin
    w_dec = '0;
    case (w_op)
      5'd0, 5'd1: begin
        w_dec.ctl.rd0   = w_a;
        w_dec.ctl.rd1   = RegMath;
        w_dec.ctl.wr    = w_b;
        w_dec.ctl.write = 1'b1;
        w_dec.ctl.aluop = (w_op == 5'd1) ? ALUOP_W'(1) : '0;
        w_dec.use_rd0   = 1'b1;
        w_dec.use_rd1   = 1'b1;
      end
      5'd2, 5'd3, 5'd8, 5'd13: begin
        w_dec.ctl.rd0   = w_a;
        w_dec.ctl.write = 1'b1;
        w_dec.ctl.move  = 1'b1;
        w_dec.use_rd0   = 1'b1;
        case (w_op)
          5'd2:    w_dec.ctl.wr = w_b;
          5'd3:    w_dec.ctl.wr = RegAdr;
          5'd8:    w_dec.ctl.wr = RegMath;
          default: w_dec.ctl.wr = RegCnt;
        endcase
      end
      5'd4, 5'd7, 5'd12: begin
        w_dec.ctl.wr    = w_b;
        w_dec.ctl.write = 1'b1;
        w_dec.ctl.move  = 1'b1;
        w_dec.use_rd0   = 1'b1;
        case (w_op)
          5'd4:    w_dec.ctl.rd0 = RegAdr;
          5'd7:    w_dec.ctl.rd0 = RegMath;
          default: w_dec.ctl.rd0 = RegCnt;
        endcase
      end
      5'd5: begin
        w_dec.ctl.wr        = RegAdr;
        w_dec.ctl.write     = 1'b1;
        w_dec.ctl.imm       = 1'b1;
        w_dec.ctl.jump_sign = instr[0];
      end
      5'd6: begin
        w_dec.ctl.rd0   = REG_W'(instr[3:0]);
        w_dec.ctl.wr    = RegMath;
        w_dec.ctl.write = 1'b1;
        w_dec.ctl.imm   = 1'b1;
        w_dec.use_rd0   = 1'b1;
      end
      5'd9, 5'd10, 5'd11: begin
        w_dec.ctl.rd1         = w_a;
        w_dec.ctl.write       = 1'b1;
        w_dec.ctl.move        = 1'b1;
        w_dec.ctl.set_quarter = 1'b1;
        w_dec.use_rd0         = 1'b1;
        w_dec.use_rd1         = 1'b1;
        case (w_op)
          5'd9:  begin w_dec.ctl.rd0 = RegMath; w_dec.ctl.wr = RegAdr; end
          5'd10: begin w_dec.ctl.rd0 = RegMath; w_dec.ctl.wr = w_b;    end
          default: begin w_dec.ctl.rd0 = w_b;   w_dec.ctl.wr = RegCnt; end
        endcase
      end
      5'd14, 5'd25: begin
        w_dec.ctl.wr    = (w_op == 5'd14) ? RegCnt : w_b;
        w_dec.ctl.write = 1'b1;
        w_dec.ctl.imm   = 1'b1;
      end
      5'd15, 5'd16, 5'd17, 5'd18, 5'd19: begin
        w_dec.ctl.rd0    = w_a;
        w_dec.ctl.rd1    = w_b;
        w_dec.ctl.branch = 1'b1;
        w_dec.use_rd0    = 1'b1;
        w_dec.use_rd1    = 1'b1;
        case (w_op)
          5'd15:   w_dec.ctl.aluop = ALUOP_W'(7);
          5'd16:   w_dec.ctl.aluop = ALUOP_W'(8);
          5'd17:   w_dec.ctl.aluop = ALUOP_W'(6);
          5'd18:   w_dec.ctl.aluop = ALUOP_W'(5);
          default: w_dec.ctl.aluop = ALUOP_W'(4);
        endcase
      end
      5'd20, 5'd21: begin
        w_dec.ctl.rd0   = w_a;
        w_dec.ctl.aluop = (w_op == 5'd20) ? ALUOP_W'(2) : ALUOP_W'(3);
        w_dec.use_rd0   = 1'b1;
      end
      5'd22, 5'd23: begin
        w_dec.ctl.rd0 = w_a;
        w_dec.ctl.rd1 = RegAdr;
        w_dec.use_rd0 = 1'b1;
        w_dec.use_rd1 = 1'b1;
        if (w_op == 5'd22) begin
          w_dec.ctl.wr         = w_b;
          w_dec.ctl.write      = 1'b1;
          w_dec.ctl.mem_to_reg = 1'b1;
        end else begin
          w_dec.ctl.mem_write = 1'b1;
        end
      end
      5'd24: begin
        w_dec.ctl.branch = 1'b1;
        w_dec.ctl.aluop  = ALUOP_W'(7);
      end
      5'd26:   w_dec.is_halt    = 1'b1;
      default: w_dec.is_illegal = 1'b1;
    endcase
  end

  // only ld sets mem_to_reg, so it identifies a pending load in the ctl register
  assign w_hazard = r_ctl_valid && r_ctl.mem_to_reg &&
                    ((w_dec.use_rd0 && (w_dec.ctl.rd0 == r_ctl.wr)) ||
                     (w_dec.use_rd1 && (w_dec.ctl.rd1 == r_ctl.wr)));

  assign w_can_load  = ex_ready || !r_ctl_valid;
  assign instr_ready = (r_state == StRun) && w_can_load && !flush;

  always_comb begin
    w_state_nxt   = r_state;
    w_ctl_nxt     = r_ctl;
    w_valid_nxt   = r_ctl_valid;
    w_skid_nxt    = r_skid;
    w_illegal_nxt = r_illegal;
    case (r_state)
      StRun: begin
        if (flush || w_can_load) begin
          w_valid_nxt = 1'b0;
          w_ctl_nxt   = '0;
        end
        if (!flush && w_can_load && instr_valid) begin
          if (w_dec.is_illegal) begin
            w_illegal_nxt = 1'b1;
          end else if (w_dec.is_halt) begin
            w_state_nxt = StHalted;
          end else if (w_hazard) begin
            // park the accepted instruction while the bubble drains the load
            w_state_nxt = StStall;
            w_skid_nxt  = w_dec.ctl;
          end else begin
            w_valid_nxt = 1'b1;
            w_ctl_nxt   = w_dec.ctl;
          end
        end
      end
      StStall: begin
        w_state_nxt = StRun;
        w_valid_nxt = !flush;
        w_ctl_nxt   = flush ? '0 : r_skid;
      end
      StHalted: w_state_nxt = StHalted;
      default:  w_state_nxt = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StRun;
      r_ctl       <= '0;
      r_skid      <= '0;
      r_ctl_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ctl       <= w_ctl_nxt;
      r_skid      <= w_skid_nxt;
      r_ctl_valid <= w_valid_nxt;
      r_illegal   <= w_illegal_nxt;
    end
  end

  assign ctl_valid   = r_ctl_valid;
  assign rd0         = r_ctl.rd0;
  assign rd1         = r_ctl.rd1;
  assign wr          = r_ctl.wr;
  assign write       = r_ctl.write;
  assign move        = r_ctl.move;
  assign mem_to_reg  = r_ctl.mem_to_reg;
  assign mem_write   = r_ctl.mem_write;
  assign branch      = r_ctl.branch;
  assign imm         = r_ctl.imm;
  assign set_quarter = r_ctl.set_quarter;
  assign jump_sign   = r_ctl.jump_sign;
  assign aluop       = r_ctl.aluop;
  assign halted      = (r_state == StHalted);
  assign illegal     = r_illegal;

endmodule
